port_ingress_ctrl: RTL

- Per-port ingress stage placed directly upstream of port_arbitrator; one instance per input port, 16 instances in total.
- Buffers incoming packets in a local FIFO and commits only complete packets.
- Drives this port's request bit into the arbitrator, retries after a back-off when refused, and streams the granted packet out with an end-of-packet flag that feeds the arbitrator's i_eop.

---
 rtl/mpc_pkg.sv | 15 +
 rtl/ingress_pkt_fifo.sv | 64 ++++++
 rtl/port_ingress_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mpc_pkg.sv
// Shared types and constants for the per-port ingress stage.
package mpc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF,
        XFER
    } ingress_state_e;

    localparam int unsigned PORT_NUM           = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned STAT_WIDTH         = 16;

endpackage

// File: rtl/ingress_pkt_fifo.sv
// Packet buffer with write, committed and read pointers. Readers only see
// committed words; rewind discards the uncommitted tail of the open packet.
module ingress_pkt_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rewind,
    input  logic             i_commit,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_cmt_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      cmt_ptr_q, cmt_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      wr_base;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Pointer next-state; a rewind writes (if at all) at the committed position.
    always_comb begin
        wr_base   = i_rewind ? cmt_ptr_q : wr_ptr_q;
        wr_ptr_d  = i_wr_en ? wr_base + 1'b1 : wr_base;
        cmt_ptr_d = i_commit ? wr_ptr_d : cmt_ptr_q;
        rd_ptr_d  = i_rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Flags: full is measured from the read pointer, empty against committed data.
    always_comb begin
        o_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        o_cmt_full = (cmt_ptr_q[AW] != rd_ptr_q[AW]) && (cmt_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        o_empty    = (rd_ptr_q == cmt_ptr_q);
        o_rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            cmt_ptr_q <= '0;
            rd_ptr_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage array, no reset needed: contents are only read once committed.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[wr_base[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/port_ingress_ctrl.sv
// Per-port ingress: buffers whole packets, requests the arbitrator, backs off
// on refusal and streams the granted packet. Define INGRESS_STAT_EN to add
// saturating forwarded/dropped packet counters.
module port_ingress_ctrl
    import mpc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 64,
    parameter int unsigned BACKOFF_CYC = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_sop,
    input  logic                  i_wr_vld,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_eop,
    output logic                  o_wr_ready,
    output logic                  o_req,
    input  logic                  i_resp,
    input  logic                  i_nresp,
    input  logic                  i_port_ready,
    output logic                  o_rd_vld,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_eop,
`ifdef INGRESS_STAT_EN
    output logic [STAT_WIDTH-1:0] o_stat_pkt,
    output logic [STAT_WIDTH-1:0] o_stat_drop,
`endif
    output logic                  o_pkt_drop
);

    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned BOW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;

    ingress_state_e      state_q, state_d;
    logic [BOW-1:0]      bo_cnt_q, bo_cnt_d;
    logic [AW:0]         pkt_cnt_q, pkt_cnt_d;
    logic                pkt_open_q, pkt_open_d;
    logic                discard_q, discard_d;
    logic                drop_q, drop_d;

    logic                fifo_wr, fifo_rewind, fifo_commit;
    logic                fifo_full, fifo_cmt_full, fifo_empty;
    logic                base_full;
    logic [DATA_WIDTH:0] head;

    ingress_pkt_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_en    (fifo_wr),
        .i_wr_data  ({i_wr_eop, i_wr_data}),
        .i_rewind   (fifo_rewind),
        .i_commit   (fifo_commit),
        .i_rd_en    (o_rd_vld),
        .o_rd_data  (head),
        .o_full     (fifo_full),
        .o_cmt_full (fifo_cmt_full),
        .o_empty    (fifo_empty)
    );

    assign o_wr_ready = ~fifo_full;
    assign o_pkt_drop = drop_q;

    // Write-side packet tracking: open/commit, overflow and orphan-sop drops.
    always_comb begin
        fifo_wr     = 1'b0;
        fifo_rewind = 1'b0;
        fifo_commit = 1'b0;
        drop_d      = 1'b0;
        pkt_open_d  = pkt_open_q;
        discard_d   = discard_q;
        // A sop on top of an open packet rewinds first, so room is judged at the commit point.
        base_full   = (i_wr_sop && pkt_open_q) ? fifo_cmt_full : fifo_full;
        if (i_wr_vld) begin
            if (i_wr_sop) begin
                discard_d = 1'b0;
                if (pkt_open_q) begin
                    fifo_rewind = 1'b1;
                    drop_d      = 1'b1;
                end
                if (base_full) begin
                    drop_d     = 1'b1;
                    pkt_open_d = 1'b0;
                    discard_d  = ~i_wr_eop;
                end else begin
                    fifo_wr     = 1'b1;
                    fifo_commit = i_wr_eop;
                    pkt_open_d  = ~i_wr_eop;
                end
            end else if (discard_q) begin
                discard_d = ~i_wr_eop;
            end else if (pkt_open_q) begin
                if (fifo_full) begin
                    fifo_rewind = 1'b1;
                    drop_d      = 1'b1;
                    pkt_open_d  = 1'b0;
                    discard_d   = ~i_wr_eop;
                end else begin
                    fifo_wr     = 1'b1;
                    fifo_commit = i_wr_eop;
                    pkt_open_d  = ~i_wr_eop;
                end
            end
        end
    end

    // Request/transfer FSM and read-side outputs; o_req depends on state only.
    always_comb begin
        state_d   = state_q;
        bo_cnt_d  = bo_cnt_q;
        o_req     = (state_q == REQ) || (state_q == XFER);
        o_rd_vld  = (state_q == XFER) && i_port_ready && ~fifo_empty;
        o_rd_eop  = o_rd_vld && head[DATA_WIDTH];
        o_rd_data = o_rd_vld ? head[DATA_WIDTH-1:0] : '0;
        case (state_q)
            IDLE: begin
                if (pkt_cnt_q != '0) state_d = REQ;
            end
            REQ: begin
                if (i_resp) begin
                    state_d = XFER;
                end else if (i_nresp) begin
                    state_d  = BACKOFF;
                    bo_cnt_d = '0;
                end
            end
            BACKOFF: begin
                if (bo_cnt_q == BOW'(BACKOFF_CYC - 1)) state_d = REQ;
                else bo_cnt_d = bo_cnt_q + 1'b1;
            end
            XFER: begin
                if (o_rd_eop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Committed-packet count; simultaneous commit and read eop cancel out.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({fifo_commit, o_rd_eop})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            bo_cnt_q   <= '0;
            pkt_cnt_q  <= '0;
            pkt_open_q <= 1'b0;
            discard_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bo_cnt_q   <= bo_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            pkt_open_q <= pkt_open_d;
            discard_q  <= discard_d;
            drop_q     <= drop_d;
        end
    end

`ifdef INGRESS_STAT_EN
    logic [STAT_WIDTH-1:0] stat_pkt_q, stat_pkt_d;
    logic [STAT_WIDTH-1:0] stat_drop_q, stat_drop_d;

    // Saturating statistics next-state.
    always_comb begin
        stat_pkt_d  = stat_pkt_q;
        stat_drop_d = stat_drop_q;
        if (o_rd_eop && stat_pkt_q != '1) stat_pkt_d = stat_pkt_q + 1'b1;
        if (drop_q && stat_drop_q != '1) stat_drop_d = stat_drop_q + 1'b1;
    end

    // Statistics registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stat_pkt_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_pkt_q  <= stat_pkt_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign o_stat_pkt  = stat_pkt_q;
    assign o_stat_drop = stat_drop_q;
`else
    // No statistics counters in this build.
`endif

endmodule
